nic_pe_sequencer: RTL and testbench
===================================

Name: nic_pe_sequencer

Overview:
- Processor-side controller for cardinal_nic; owns the NIC processor port (addr, d_in, d_out, nicEn, nicWrEn).
- Polls the NIC RX and TX status registers and loads received flits into a one-entry hold register.
- Presents held flits to a local consumer over valid/ready.
- Round-robin arbitrates two local flit sources (A, B) onto the single NIC TX store path. RX and TX service alternate so neither starves.

Parameters:
- DATA_W, 64, flit width; matches cardinal_nic DATA_W.
- CNT_W, 16, width of the tx_cnt/rx_cnt statistics counters.

Ports:
- clk  in  1  system clock, all state on posedge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- txa_valid  in  1  source A has a flit.
- txa_data  in  DATA_W  source A flit.
- txa_ready  out  1  source A flit accepted this cycle.
- txb_valid  in  1  source B has a flit.
- txb_data  in  DATA_W  source B flit.
- txb_ready  out  1  source B flit accepted this cycle.
- rx_valid  out  1  hold register contains a received flit.
- rx_data  out  DATA_W  received flit.
- rx_ready  in  1  consumer takes the flit.
- nic_addr  out  2  to NIC addr: 00 RX buf, 01 RX status, 10 TX buf, 11 TX status.
- nic_d_in  out  DATA_W  to NIC d_in.
- nic_d_out  in  DATA_W  from NIC d_out; status is in bit DATA_W-1; valid the cycle after a load.
- nic_en  out  1  to NIC nicEn.
- nic_wr_en  out  1  to NIC nicWrEn.
- tx_cnt  out  CNT_W  flits stored to NIC, wraps modulo 2^CNT_W.
- rx_cnt  out  CNT_W  flits loaded from NIC, wraps.

Behaviour:
- Reset (async, reset=0) forces:
  - state=IDLE, nic_en=0, nic_wr_en=0, nic_addr=00, nic_d_in=0.
  - rx_valid=0, rx_data=0, txa_ready=0, txb_ready=0, tx_cnt=0, rx_cnt=0.
  - rr_last=B (A wins first tie), phase=RX.
- Reset mid-operation aborts any transaction; no partial store or handshake.
- FSM outputs are Moore, decoded from the state register:
  - IDLE, EVAL_RX, CAPT_RX, EVAL_TX: nic_en=0, nic_wr_en=0.
  - POLL_RX: addr=01, nic_en=1.
  - READ_RX: addr=00, nic_en=1.
  - POLL_TX: addr=11, nic_en=1.
  - STORE: addr=10, nic_en=1, nic_wr_en=1, nic_d_in=granted source data, granted *_ready=1.
- IDLE transitions:
  - rx_can = !rx_valid; tx_can = txa_valid | txb_valid.
  - Both true: go to POLL_RX if phase=RX, else POLL_TX. Only one true: go to that one. Neither: stay in IDLE.
- POLL_RX -> EVAL_RX.
- EVAL_RX: nic_d_out[DATA_W-1]=1 -> READ_RX; else IDLE. Either way phase<=TX.
- READ_RX -> CAPT_RX.
- CAPT_RX:
  - rx_data<=nic_d_out, rx_valid<=1, rx_cnt++.
  - Go to IDLE.
  - RX buffer address 00 is loaded only after status=1.
- POLL_TX -> EVAL_TX.
- EVAL_TX:
  - Condition: status bit=0 and tx_can. If met, latch grant and go to STORE; otherwise go to IDLE. Either way phase<=RX.
  - Grant: only one valid -> that one; both -> source != rr_last.
- STORE:
  - Single cycle; handshake completes this cycle.
  - tx_cnt++, rr_last<=granted source, go to IDLE.
- Sources must hold valid and data stable until ready; ready is never asserted without a STORE.
- Consumer side:
  - rx_valid stays 1 until a cycle with rx_valid & rx_ready; then clears on that edge.
  - No NIC RX polling while rx_valid=1.
- Latency from IDLE:
  - TX: store 3 cycles after leaving IDLE (POLL_TX, EVAL_TX, STORE).
  - RX: rx_valid rises 4 edges after leaving IDLE.
- A status read reporting full TX (1) or empty RX (0) costs the 2-cycle poll, then the FSM returns to IDLE; retry is unbounded.
- Counters wrap from 2^CNT_W-1 to 0 silently.

Test Plan:
- Reset: assert reset=0 mid-STORE -> all outputs return to reset values immediately (async), txa_ready=0; after release, nic_en=0 and counters are 0.
- TX single:
  - Stimulus: txa_valid=1, txa_data=64'h0123456789ABCDEF, NIC TX status=0.
  - Response: sequence addr 11 load, idle, addr 10 store with nic_d_in=that value; txa_ready=1 for exactly one cycle; tx_cnt=1.
- TX busy:
  - Stimulus: NIC TX status=1 for 3 polls, then 0.
  - Response: three POLL_TX/EVAL_TX pairs with no store, then one store; txa_ready is pulsed exactly once.
- Round-robin:
  - Stimulus: txa_valid=1 and txb_valid=1 held with distinct data; each source drops valid for the cycle after its ready pulse and re-asserts.
  - Response: grants are A,B,A,B over 4 stores; tx_cnt=4.
- RX hold and backpressure:
  - Stimulus: NIC RX status=1 with buffer 64'hF0E1D2C3B4A59687; rx_ready=0 for 5 cycles, then 1.
  - Response: rx_valid=1 with that data held across the stall; no addr 01/00 loads while held; rx_valid clears on the handshake edge; rx_cnt=1.
- Fairness and wrap:
  - Stimulus: continuous RX full and TX pending.
  - Response: polls alternate RX, TX, RX, TX.
  - With CNT_W=2, after 5 stores tx_cnt=1.

Source files
------------

// File: rtl/nic_pe_sequencer.sv
// Processor-side sequencer for cardinal_nic: polls RX/TX status, holds one received
// flit for a local consumer, and round-robins two local sources onto the NIC store path.
module nic_pe_sequencer #(
  parameter int DATA_W = 64,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              txa_valid,
  input  logic [DATA_W-1:0] txa_data,
  output logic              txa_ready,
  input  logic              txb_valid,
  input  logic [DATA_W-1:0] txb_data,
  output logic              txb_ready,
  output logic              rx_valid,
  output logic [DATA_W-1:0] rx_data,
  input  logic              rx_ready,
  output logic [1:0]        nic_addr,
  output logic [DATA_W-1:0] nic_d_in,
  input  logic [DATA_W-1:0] nic_d_out,
  output logic              nic_en,
  output logic              nic_wr_en,
  output logic [CNT_W-1:0]  tx_cnt,
  output logic [CNT_W-1:0]  rx_cnt
);

  typedef enum logic [2:0] {
    IDLE, POLL_RX, EVAL_RX, READ_RX, CAPT_RX, POLL_TX, EVAL_TX, STORE
  } state_t;

  localparam logic PH_RX = 1'b0;
  localparam logic PH_TX = 1'b1;
  localparam logic SRC_A = 1'b0;
  localparam logic SRC_B = 1'b1;

  state_t              state_q, state_d;
  logic                phase_q, phase_d;
  logic                rr_last_q, rr_last_d;
  logic                grant_q, grant_d;
  logic                rx_valid_q, rx_valid_d;
  logic [DATA_W-1:0]   rx_data_q, rx_data_d;
  logic [CNT_W-1:0]    tx_cnt_q, tx_cnt_d;
  logic [CNT_W-1:0]    rx_cnt_q, rx_cnt_d;

  logic rx_can, tx_can, nic_status;

  assign rx_can     = !rx_valid_q;
  assign tx_can     = txa_valid | txb_valid;
  assign nic_status = nic_d_out[DATA_W-1];

  assign rx_valid = rx_valid_q;
  assign rx_data  = rx_data_q;
  assign tx_cnt   = tx_cnt_q;
  assign rx_cnt   = rx_cnt_q;

  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    rr_last_d  = rr_last_q;
    grant_d    = grant_q;
    rx_valid_d = rx_valid_q;
    rx_data_d  = rx_data_q;
    tx_cnt_d   = tx_cnt_q;
    rx_cnt_d   = rx_cnt_q;
    nic_en     = 1'b0;
    nic_wr_en  = 1'b0;
    nic_addr   = 2'b00;
    nic_d_in   = '0;
    txa_ready  = 1'b0;
    txb_ready  = 1'b0;

    if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        // phase only breaks ties; a lone request is always served
        if (rx_can && tx_can)  state_d = (phase_q == PH_RX) ? POLL_RX : POLL_TX;
        else if (rx_can)       state_d = POLL_RX;
        else if (tx_can)       state_d = POLL_TX;
      end
      POLL_RX: begin
        nic_en   = 1'b1;
        nic_addr = 2'b01;
        state_d  = EVAL_RX;
      end
      EVAL_RX: begin
        phase_d = PH_TX;
        state_d = nic_status ? READ_RX : IDLE;
      end
      READ_RX: begin
        nic_en   = 1'b1;
        nic_addr = 2'b00;
        state_d  = CAPT_RX;
      end
      CAPT_RX: begin
        rx_data_d  = nic_d_out;
        rx_valid_d = 1'b1;
        rx_cnt_d   = rx_cnt_q + CNT_W'(1);
        state_d    = IDLE;
      end
      POLL_TX: begin
        nic_en   = 1'b1;
        nic_addr = 2'b11;
        state_d  = EVAL_TX;
      end
      EVAL_TX: begin
        phase_d = PH_RX;
        if (!nic_status && tx_can) begin
          grant_d = (txa_valid && txb_valid) ? ~rr_last_q : (txb_valid ? SRC_B : SRC_A);
          state_d = STORE;
        end else begin
          state_d = IDLE;
        end
      end
      STORE: begin
        nic_en    = 1'b1;
        nic_wr_en = 1'b1;
        nic_addr  = 2'b10;
        nic_d_in  = (grant_q == SRC_B) ? txb_data : txa_data;
        txa_ready = (grant_q == SRC_A);
        txb_ready = (grant_q == SRC_B);
        tx_cnt_d  = tx_cnt_q + CNT_W'(1);
        rr_last_d = grant_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      phase_q    <= PH_RX;
      rr_last_q  <= SRC_B;
      grant_q    <= SRC_A;
      rx_valid_q <= 1'b0;
      rx_data_q  <= '0;
      tx_cnt_q   <= '0;
      rx_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      rr_last_q  <= rr_last_d;
      grant_q    <= grant_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
      tx_cnt_q   <= tx_cnt_d;
      rx_cnt_q   <= rx_cnt_d;
    end
  end

endmodule

// File: tb/tb_nic_pe_sequencer.sv
// Bench for nic_pe_sequencer: behavioural NIC, two flit sources, a transaction-level
// reference model checked every cycle, and directed scenarios with literal expectations.
module tb_nic_pe_sequencer;
  localparam int DATA_W = 64;
  localparam int CNT_W  = 16;
  localparam int OP_NONE = 0, OP_LD00 = 1, OP_LD01 = 2, OP_LD11 = 3, OP_ST = 4, OP_BAD = 5;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic              txa_valid, txb_valid, txa_ready, txb_ready;
  logic [DATA_W-1:0] txa_data, txb_data;
  logic              rx_valid;
  logic              rx_ready = 1'b0;
  logic [DATA_W-1:0] rx_data;
  logic [1:0]        nic_addr;
  logic [DATA_W-1:0] nic_d_in;
  logic [DATA_W-1:0] nic_d_out = '0;
  logic              nic_en, nic_wr_en;
  logic [CNT_W-1:0]  tx_cnt, rx_cnt;

  nic_pe_sequencer #(.DATA_W(DATA_W), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .reset(reset),
    .txa_valid(txa_valid), .txa_data(txa_data), .txa_ready(txa_ready),
    .txb_valid(txb_valid), .txb_data(txb_data), .txb_ready(txb_ready),
    .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
    .nic_addr(nic_addr), .nic_d_in(nic_d_in), .nic_d_out(nic_d_out),
    .nic_en(nic_en), .nic_wr_en(nic_wr_en), .tx_cnt(tx_cnt), .rx_cnt(rx_cnt)
  );

  // Narrow-counter instance for wrap checking; its NIC always reports TX free, RX empty.
  logic              w_txa_valid = 1'b0;
  logic [DATA_W-1:0] w_txa_data = 64'h5555_0000_0000_00AA;
  logic              w_txa_ready, w_txb_ready, w_rx_valid, w_nic_en, w_nic_wr_en;
  logic [DATA_W-1:0] w_rx_data, w_nic_d_in;
  logic [DATA_W-1:0] w_nic_d_out = '0;
  logic [1:0]        w_nic_addr, w_tx_cnt, w_rx_cnt;

  nic_pe_sequencer #(.DATA_W(DATA_W), .CNT_W(2)) u_wrap (
    .clk(clk), .reset(reset),
    .txa_valid(w_txa_valid), .txa_data(w_txa_data), .txa_ready(w_txa_ready),
    .txb_valid(1'b0), .txb_data(64'h0), .txb_ready(w_txb_ready),
    .rx_valid(w_rx_valid), .rx_data(w_rx_data), .rx_ready(1'b1),
    .nic_addr(w_nic_addr), .nic_d_in(w_nic_d_in), .nic_d_out(w_nic_d_out),
    .nic_en(w_nic_en), .nic_wr_en(w_nic_wr_en), .tx_cnt(w_tx_cnt), .rx_cnt(w_rx_cnt)
  );

  int n_vec = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  // Behavioural NIC: status in the MSB, load data appears the cycle after the load.
  int          tx_polls_seen = 0;
  int          tx_busy_until = 0;
  int          rx_taken = 0;
  int          rx_avail = 0;
  logic        rx_sticky = 1'b0;
  logic [63:0] rx_buf = '0;
  logic        rx_full;
  assign rx_full = rx_sticky || (rx_taken < rx_avail);

  always @(posedge clk) begin
    if (nic_en && !nic_wr_en) begin
      case (nic_addr)
        2'b00: begin nic_d_out <= rx_buf; rx_taken <= rx_taken + 1; end
        2'b01: nic_d_out <= {rx_full, 63'b0};
        2'b11: begin
          nic_d_out <= {(tx_polls_seen < tx_busy_until), 63'b0};
          tx_polls_seen <= tx_polls_seen + 1;
        end
        default: nic_d_out <= nic_d_out;
      endcase
    end
  end

  // Flit sources: hold valid until ready, drop for one cycle, re-offer while quota remains.
  int          a_served, b_served;
  int          a_quota = 0, b_quota = 0;
  logic [63:0] a_seed = '0, b_seed = '0;

  initial begin : src_a
    txa_valid = 1'b0; txa_data = '0; a_served = 0;
    forever begin
      @(negedge clk);
      if (txa_valid && txa_ready) begin
        a_served = a_served + 1;
        @(posedge clk); #1;
        txa_valid = 1'b0;
      end else if (!txa_valid && a_served < a_quota) begin
        @(posedge clk); #1;
        txa_data  = a_seed + 64'(a_served);
        txa_valid = 1'b1;
      end
    end
  end

  initial begin : src_b
    txb_valid = 1'b0; txb_data = '0; b_served = 0;
    forever begin
      @(negedge clk);
      if (txb_valid && txb_ready) begin
        b_served = b_served + 1;
        @(posedge clk); #1;
        txb_valid = 1'b0;
      end else if (!txb_valid && b_served < b_quota) begin
        @(posedge clk); #1;
        txb_data  = b_seed + 64'(b_served);
        txb_valid = 1'b1;
      end
    end
  end

  // Reference model: derives the required bus activity and outputs from what the NIC
  // reported and what the sources offered, then compares on every cycle out of reset.
  int          n_ld00 = 0, n_ld01 = 0, n_ld11 = 0, n_store = 0, n_ra = 0, n_rb = 0, fair_n = 0;
  logic [63:0] last_store_data = '0;
  logic [7:0]  grant_bits = '0;
  logic        fair_on = 1'b0;

  initial begin : compare
    int op, op_m1, op_m2, fair_last;
    logic ev_stat, ev_va, ev_vb, rs_stat, exp_store, exp_ld00, g_b, hs_prev, prev_valid, rr_m;
    logic exp_valid;
    logic [63:0] exp_data, cap_data;
    logic [15:0] exp_tx, exp_rx;
    forever begin
      @(negedge clk);
      if (!reset) begin
        op_m1 = OP_NONE; op_m2 = OP_NONE; fair_last = OP_NONE;
        ev_stat = 1'b1; ev_va = 1'b0; ev_vb = 1'b0; rs_stat = 1'b0;
        hs_prev = 1'b0; rr_m = 1'b1; exp_valid = 1'b0;
        exp_data = '0; cap_data = '0; exp_tx = '0; exp_rx = '0;
      end else begin
        op = OP_NONE;
        if (nic_wr_en) op = OP_ST;
        else if (nic_en) begin
          case (nic_addr)
            2'b00:   op = OP_LD00;
            2'b01:   op = OP_LD01;
            2'b11:   op = OP_LD11;
            default: op = OP_BAD;
          endcase
        end
        chk("bus_strobes", {63'b0, (nic_wr_en && !(nic_en && nic_addr == 2'b10)) || op == OP_BAD}, 64'd0);

        prev_valid = exp_valid;
        if (op_m1 == OP_ST) exp_tx++;
        if (hs_prev) exp_valid = 1'b0;
        if (op_m2 == OP_LD00) begin exp_valid = 1'b1; exp_data = cap_data; exp_rx++; end
        exp_store = (op_m2 == OP_LD11) && !ev_stat && (ev_va || ev_vb);
        exp_ld00  = (op_m2 == OP_LD01) && rs_stat;
        g_b       = (ev_va && ev_vb) ? !rr_m : ev_vb;

        chk("store_sequence", op == OP_ST, exp_store);
        chk("rxbuf_sequence", op == OP_LD00, exp_ld00);
        chk("txa_ready", txa_ready, exp_store && !g_b);
        chk("txb_ready", txb_ready, exp_store && g_b);
        if (op == OP_LD01) chk("rx_poll_while_held", prev_valid, 1'b0);
        if (op == OP_ST) begin
          chk("store_data", nic_d_in, g_b ? txb_data : txa_data);
          rr_m = g_b;
          n_store++;
          last_store_data = nic_d_in;
          grant_bits = {grant_bits[6:0], txb_ready};
        end
        chk("rx_valid", rx_valid, exp_valid);
        chk("rx_data", rx_data, exp_data);
        chk("rx_cnt", rx_cnt, exp_rx);
        chk("tx_cnt", tx_cnt, exp_tx);

        if (txa_ready) n_ra++;
        if (txb_ready) n_rb++;
        if (op == OP_LD00) n_ld00++;
        if (op == OP_LD01) n_ld01++;
        if (op == OP_LD11) n_ld11++;

        if (op_m1 == OP_LD11) begin ev_stat = nic_d_out[63]; ev_va = txa_valid; ev_vb = txb_valid; end
        if (op_m1 == OP_LD01) rs_stat = nic_d_out[63];
        if (op_m1 == OP_LD00) cap_data = nic_d_out;

        if (fair_on) begin
          if (op == OP_LD01 || op == OP_LD11) begin
            if (fair_last != OP_NONE) begin
              chk("poll_alternation", op != fair_last, 1'b1);
              fair_n++;
            end
            fair_last = op;
          end
        end else begin
          fair_last = OP_NONE;
        end

        hs_prev = exp_valid && rx_ready;
        op_m2 = op_m1;
        op_m1 = op;
      end
    end
  end

  initial begin : stimulus
    int s_ra, s_ld11, s_store, s_ld, s_ld00, cyc, k;

    // Reset values while reset is held
    repeat (3) @(posedge clk);
    #1;
    chk("rst_nic_en", nic_en, 0);
    chk("rst_nic_wr_en", nic_wr_en, 0);
    chk("rst_nic_addr", nic_addr, 0);
    chk("rst_nic_d_in", nic_d_in, 0);
    chk("rst_rx_valid", rx_valid, 0);
    chk("rst_rx_data", rx_data, 0);
    chk("rst_ready", {txa_ready, txb_ready}, 0);
    chk("rst_counters", {tx_cnt, rx_cnt}, 0);
    @(negedge clk); #1 reset = 1'b1;

    // Single TX flit from A, NIC TX free
    s_ra = n_ra; s_ld11 = n_ld11;
    a_seed = 64'h0123456789ABCDEF;
    a_quota = a_served + 1;
    cyc = 0;
    while (a_served < a_quota && cyc < 100) begin @(negedge clk); cyc++; end
    chk("tx_single_done", a_served >= a_quota, 1);
    repeat (3) @(posedge clk);
    chk("tx_single_ready_cycles", n_ra - s_ra, 1);
    chk("tx_single_polls", n_ld11 - s_ld11, 1);
    chk("tx_single_data", last_store_data, 64'h0123456789ABCDEF);
    chk("tx_single_cnt", tx_cnt, 1);

    // NIC TX busy for three polls, then free
    s_ra = n_ra; s_ld11 = n_ld11; s_store = n_store;
    tx_busy_until = tx_polls_seen + 3;
    a_seed = 64'hAAAA_0000_0000_0001;
    a_quota = a_served + 1;
    cyc = 0;
    while (a_served < a_quota && cyc < 200) begin @(negedge clk); cyc++; end
    chk("tx_busy_done", a_served >= a_quota, 1);
    repeat (3) @(posedge clk);
    chk("tx_busy_polls", n_ld11 - s_ld11, 4);
    chk("tx_busy_stores", n_store - s_store, 1);
    chk("tx_busy_ready_cycles", n_ra - s_ra, 1);
    chk("tx_busy_cnt", tx_cnt, 2);

    // Asynchronous reset in the middle of a store
    a_seed = 64'hDEAD_BEEF_0000_0000;
    a_quota = a_served + 1;
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!nic_wr_en && cyc < 100);
    chk("reset_store_reached", nic_wr_en, 1);
    #1 reset = 1'b0;
    #1;
    chk("arst_txa_ready", txa_ready, 0);
    chk("arst_nic_en", nic_en, 0);
    chk("arst_nic_wr_en", nic_wr_en, 0);
    chk("arst_nic_addr", nic_addr, 0);
    chk("arst_nic_d_in", nic_d_in, 0);
    chk("arst_counters", {tx_cnt, rx_cnt}, 0);
    @(negedge clk); #1 reset = 1'b1;
    #1;
    chk("post_rst_nic_en", nic_en, 0);
    chk("post_rst_tx_cnt", tx_cnt, 0);

    // Round-robin: both sources offer two flits each
    s_store = n_store;
    a_seed = 64'hA000_0000_0000_0000;
    b_seed = 64'hB000_0000_0000_0000;
    a_quota = a_served + 2;
    b_quota = b_served + 2;
    cyc = 0;
    while ((a_served < a_quota || b_served < b_quota) && cyc < 400) begin @(negedge clk); cyc++; end
    chk("rr_done", (a_served >= a_quota) && (b_served >= b_quota), 1);
    repeat (3) @(posedge clk);
    chk("rr_stores", n_store - s_store, 4);
    chk("rr_grant_order", grant_bits[3:0], 4'b0101);
    chk("rr_tx_cnt", tx_cnt, 4);

    // RX hold with consumer backpressure
    s_ld00 = n_ld00;
    rx_buf = 64'hF0E1D2C3B4A59687;
    rx_avail = rx_taken + 1;
    cyc = 0;
    do begin @(negedge clk); cyc++; end while (!rx_valid && cyc < 100);
    s_ld = n_ld00 + n_ld01;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rx_hold_valid", rx_valid, 1);
      chk("rx_hold_data", rx_data, 64'hF0E1D2C3B4A59687);
    end
    chk("rx_hold_no_loads", n_ld00 + n_ld01 - s_ld, 0);
    @(posedge clk); #1 rx_ready = 1'b1;
    @(negedge clk);
    chk("rx_valid_before_hs", rx_valid, 1);
    @(posedge clk); #1;
    chk("rx_valid_after_hs", rx_valid, 0);
    chk("rx_cnt_one", rx_cnt, 1);
    chk("rx_buf_loads", n_ld00 - s_ld00, 1);

    // Fairness: RX permanently full and A permanently pending
    rx_sticky = 1'b1;
    a_seed = 64'h0F0F_0000_0000_0000;
    a_quota = a_served + 1000;
    @(posedge clk); #1 fair_on = 1'b1;
    cyc = 0;
    while (fair_n < 8 && cyc < 400) begin @(negedge clk); cyc++; end
    chk("fair_polls_seen", fair_n >= 8, 1);
    @(posedge clk); #1;
    fair_on = 1'b0;
    rx_sticky = 1'b0;
    a_quota = a_served;

    // Counter wrap on the 2-bit instance
    @(posedge clk); #1 w_txa_valid = 1'b1;
    k = 0; cyc = 0;
    while (k < 5 && cyc < 400) begin
      @(negedge clk); cyc++;
      if (w_txa_ready) begin
        k++;
        chk("wrap_store_bus", {w_nic_en, w_nic_wr_en, w_nic_addr, w_txb_ready}, {1'b1, 1'b1, 2'b10, 1'b0});
        chk("wrap_store_data", w_nic_d_in, 64'h5555_0000_0000_00AA);
      end
    end
    chk("wrap_stores", k, 5);
    @(posedge clk); #1 w_txa_valid = 1'b0;
    chk("wrap_tx_cnt", w_tx_cnt, 2'd1);
    chk("wrap_rx_side", {w_rx_valid, w_rx_cnt}, 0);
    chk("wrap_rx_data", w_rx_data, 0);

    repeat (4) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
